// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared state encoding and even-parity helper for serial_bit_source
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    // Widest word the parity helper accepts; callers zero-extend narrower words.
    localparam int PAR_MAX_WIDTH = 64;

    function automatic logic even_parity(input logic [PAR_MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// rtl/ser_bit_counter.sv - loadable down-counter with zero flag for the serializer bit index
module ser_bit_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] count;

    // Saturates at zero so a stalled SHIFT-at-last-bit never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/serial_bit_source.sv
// rtl/serial_bit_source.sv - word-to-bit serializer with valid/ready input; optional SER_PARITY_EN appends even parity
module serial_bit_source
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    ser_state_t       state;
    ser_state_t       state_next;
    logic [WIDTH-1:0] sr;
    logic             cnt_zero;
    logic             transfer;

    assign transfer = din_valid && din_ready;

    ser_bit_counter #(
        .CW(CW)
    ) u_bit_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (transfer),
        .load_value(LAST_IDX),
        .dec       (state == SHIFT),
        .zero      (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // din_ready depends only on state so the source never sees a ready/valid loop.
    always_comb begin
        state_next = state;
        din_ready  = 1'b0;
        case (state)
            IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_zero) begin
`ifdef SER_PARITY_EN
                    state_next = PARITY;
`else
                    din_ready  = 1'b1;
                    state_next = din_valid ? SHIFT : IDLE;
`endif
                end
            end
            PARITY: begin
                din_ready  = 1'b1;
                state_next = din_valid ? SHIFT : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (transfer) begin
            sr <= din;
        end else if (state == SHIFT) begin
            sr <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
        end
    end

`ifdef SER_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (transfer) begin
            parity_q <= even_parity(PAR_MAX_WIDTH'(din));
        end
    end
`endif

    always_comb begin
        x_out = IDLE_BIT;
        case (state)
            SHIFT:   x_out = MSB_FIRST ? sr[WIDTH-1] : sr[0];
`ifdef SER_PARITY_EN
            PARITY:  x_out = parity_q;
`endif
            default: x_out = IDLE_BIT;
        endcase
    end

    assign x_valid = (state != IDLE);
    assign busy    = x_valid;

endmodule

// File: tb/tb_serial_bit_source.sv
// tb/tb_serial_bit_source.sv - bench for serial_bit_source (MSB-first and LSB-first instances, SER_PARITY_EN aware)
module tb_serial_bit_source;

    localparam int W = 5;
`ifdef SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         ready_m, xo_m, xv_m, busy_m;
    logic         ready_l, xo_l, xv_l, busy_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(ready_m), .x_out(xo_m), .x_valid(xv_m), .busy(busy_m)
    );

    serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(ready_l), .x_out(xo_l), .x_valid(xv_l), .busy(busy_l)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queues of bits still to appear on each x_out, head = current bit.
    bit q_m[$];
    bit q_l[$];
    bit accepted;

    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) q_m.push_back(w[i]);
        for (int i = 0; i < W; i++) q_l.push_back(w[i]);
        if (PAR) begin
            q_m.push_back(^w);
            q_l.push_back(^w);
        end
    endtask

    task automatic check_outputs(input string tag);
        bit has;
        has = (q_m.size() > 0);
        chk({tag, "_xv_m"}, xv_m, has);
        chk({tag, "_xv_l"}, xv_l, has);
        chk({tag, "_busy"}, busy_m, has);
        chk({tag, "_xo_m"}, xo_m, has ? q_m[0] : 1'b0);
        chk({tag, "_xo_l"}, xo_l, has ? q_l[0] : 1'b1);
    endtask

    task automatic model_step(input logic v, input logic [W-1:0] d, input string tag);
        bit exp_ready;
        @(negedge clk);
        din_valid = v;
        din       = d;
        #1;
        exp_ready = (q_m.size() <= 1);
        chk({tag, "_ready_m"}, ready_m, exp_ready);
        chk({tag, "_ready_l"}, ready_l, exp_ready);
        @(posedge clk);
        if (q_m.size() > 0) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
        end
        accepted = v && exp_ready;
        if (accepted) push_word(d);
        #1;
        check_outputs(tag);
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         rdy;
        logic         xm;
        logic         xl;
        logic         xv;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic rdy,
                                input logic xm, input logic xl, input logic xv);
        vec_t r;
        r.v = v; r.d = d; r.rdy = rdy; r.xm = xm; r.xl = xl; r.xv = xv;
        return r;
    endfunction

    initial begin
        logic         cur_v;
        logic [W-1:0] cur_d;

        rst       = 1'b1;
        din_valid = 1'b0;
        din       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_xv_m", xv_m, 1'b0);
        chk("rst_xv_l", xv_l, 1'b0);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_xo_m", xo_m, 1'b0);
        chk("rst_xo_l", xo_l, 1'b1);
        chk("rst_ready", ready_m, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Two words back-to-back; din changes to the second word while the first is in flight.
`ifdef SER_PARITY_EN
        vt.push_back(mk(1, 5'b11010, 1, 1, 0, 1));
        vt.push_back(mk(1, 5'b10101, 0, 1, 1, 1));
        vt.push_back(mk(1, 5'b10101, 0, 0, 0, 1));
        vt.push_back(mk(1, 5'b10101, 0, 1, 1, 1));
        vt.push_back(mk(1, 5'b10101, 0, 0, 1, 1));
        vt.push_back(mk(1, 5'b10101, 0, 1, 1, 1));
        vt.push_back(mk(1, 5'b10101, 1, 1, 1, 1));
        vt.push_back(mk(0, 5'b00000, 0, 0, 0, 1));
        vt.push_back(mk(0, 5'b00000, 0, 1, 1, 1));
        vt.push_back(mk(0, 5'b00000, 0, 0, 0, 1));
        vt.push_back(mk(0, 5'b00000, 0, 1, 1, 1));
        vt.push_back(mk(0, 5'b00000, 0, 1, 1, 1));
        vt.push_back(mk(0, 5'b00000, 1, 0, 1, 0));
`else
        vt.push_back(mk(1, 5'b11010, 1, 1, 0, 1));
        vt.push_back(mk(1, 5'b10101, 0, 1, 1, 1));
        vt.push_back(mk(1, 5'b10101, 0, 0, 0, 1));
        vt.push_back(mk(1, 5'b10101, 0, 1, 1, 1));
        vt.push_back(mk(1, 5'b10101, 0, 0, 1, 1));
        vt.push_back(mk(1, 5'b10101, 1, 1, 1, 1));
        vt.push_back(mk(0, 5'b00000, 0, 0, 0, 1));
        vt.push_back(mk(0, 5'b00000, 0, 1, 1, 1));
        vt.push_back(mk(0, 5'b00000, 0, 0, 0, 1));
        vt.push_back(mk(0, 5'b00000, 0, 1, 1, 1));
        vt.push_back(mk(0, 5'b00000, 1, 0, 1, 0));
`endif
        vt.push_back(mk(0, 5'b00000, 1, 0, 1, 0));

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            din_valid = vt[i].v;
            din       = vt[i].d;
            #1;
            chk($sformatf("vec%0d_ready", i), ready_m, vt[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_xo_m", i), xo_m, vt[i].xm);
            chk($sformatf("vec%0d_xo_l", i), xo_l, vt[i].xl);
            chk($sformatf("vec%0d_xv", i), xv_m, vt[i].xv);
        end

        // Reset while the third bit of 11010 is on x_out.
        model_step(1'b1, 5'b11010, "rmid_load");
        model_step(1'b0, 5'b00000, "rmid_b2");
        model_step(1'b0, 5'b00000, "rmid_b3");
        @(negedge clk);
        rst = 1'b1;
        q_m.delete();
        q_l.delete();
        #1;
        chk("rmid_async_xv", xv_m, 1'b0);
        chk("rmid_async_busy", busy_l, 1'b0);
        chk("rmid_async_xo_m", xo_m, 1'b0);
        chk("rmid_async_xo_l", xo_l, 1'b1);
        chk("rmid_async_ready", ready_m, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) model_step(1'b0, 5'b00000, "rmid_after");

        // Reset and an offered word on the same edge: the word must be dropped.
        @(negedge clk);
        rst       = 1'b1;
        din_valid = 1'b1;
        din       = 5'b11010;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        din_valid = 1'b0;
        for (int i = 0; i < 2; i++) model_step(1'b0, 5'b00000, "rsim_after");

        // Randomized traffic; a pending word is held until accepted.
        cur_v    = 1'b0;
        cur_d    = '0;
        accepted = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!cur_v || accepted) begin
                cur_v = ($urandom_range(0, 3) != 0);
                cur_d = W'($urandom);
            end
            model_step(cur_v, cur_d, "rand");
        end
        for (int i = 0; i < W + 2; i++) model_step(1'b0, 5'b00000, "drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_bit_source.md
# serial_bit_source

Parallel-to-serial front end for the sequence-detector FSMs. Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on `x_out`, qualified by `x_valid`. Its output drives the `x_in` input of the Moore pattern detectors, which sample one bit per rising edge. Words may be streamed back-to-back with no idle gap between them.

## Interface
- `WIDTH`, default 8: word length in bits, ≥2.
- `MSB_FIRST`, default 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- `IDLE_BIT`, default 0: value driven on `x_out` whenever `x_valid` = 0.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `din` input WIDTH: word to serialize.
- `din_valid` input 1: `din` holds a word.
- `din_ready` output 1: the block will accept `din` at this edge.
- `x_out` output 1: serial bit to the detector `x_in`.
- `x_valid` output 1: `x_out` carries a payload or parity bit.
- `busy` output 1: a word is in flight (state ≠ IDLE).

## Operation
- States:
  - IDLE: nothing to send.
  - SHIFT: shift register `sr` and bit counter `cnt` active.
  - PARITY: exists only with `SER_PARITY_EN`.
- Transfer: a word is accepted on any rising edge with `din_valid && din_ready`.
- IDLE → SHIFT on a transfer. Load `sr` = `din` and set `cnt` = WIDTH-1.
- SHIFT, each edge: shift `sr` toward the output end and decrement `cnt`.
- SHIFT when `cnt` == 0:
  - If the parity bit is enabled, go to PARITY.
  - Otherwise, if a transfer occurs this edge, reload and stay in SHIFT.
  - Otherwise go to IDLE.
- PARITY, after one cycle: on a transfer, reload and go to SHIFT; otherwise go to IDLE.
- `din_ready` is combinational from state only, never from `din_valid`. It is high when:
  - state == IDLE, or
  - the final bit of the word is on `x_out`: SHIFT with `cnt` == 0 and no parity, or PARITY.
- `x_out`:
  - In SHIFT, equals `sr[WIDTH-1]` when MSB_FIRST = 1, else `sr[0]`.
  - In PARITY, equals the stored parity bit.
  - In IDLE, equals IDLE_BIT.
- `x_valid` = (state ≠ IDLE). `busy` is identical to `x_valid`.
- The outputs are registered state. They are not combinational from `din`.
- Parity: even parity, equal to the XOR of all WIDTH bits. It is computed from `din` at load and held in a register.
- `din_valid` high while `din_ready` is low: ignored. `din` is not sampled and no word is lost or duplicated. The source must hold the word until a transfer occurs.

## Timing
- Reset, applied asynchronously:
  - state = IDLE, `sr` = 0, `cnt` = 0, parity register = 0.
  - `x_valid` = 0, `busy` = 0, `x_out` = IDLE_BIT, `din_ready` = 1.
- Latency: the first bit appears on `x_out` in the cycle immediately after the accepting edge.
- A word occupies WIDTH consecutive cycles, or WIDTH+1 with parity.
- Back-to-back: a transfer at the final-bit edge gives a continuous `x_valid` with zero gap.
- Reset mid-word: the word is discarded and outputs go to their reset values immediately. Nothing resumes after reset is released.
- Simultaneous reset and transfer: reset wins and the word is not accepted.
- `cnt` width is $clog2(WIDTH). It never wraps below 0, because the state leaves SHIFT at 0.

## Configuration
- `SER_PARITY_EN` defined:
  - The PARITY state and parity register are compiled in.
  - Every word is followed by one even-parity bit, with `x_valid` high.
  - `din_ready` asserts in PARITY, not at the last payload bit.
- Undefined: no PARITY state and no parity register. A word is exactly WIDTH bits.

## Structure
- Package `ser_pkg`:
  - state enum `ser_state_t` (IDLE, SHIFT, PARITY);
  - the even-parity function.
- Sub-module `ser_bit_counter`: loadable down-counter with load, decrement and `zero` flag. The top level instantiates it once.

## Test plan
- WIDTH = 5, MSB_FIRST = 1, `din` = 5'b11010, single transfer:
  - `x_out` = 1,1,0,1,0 on the 5 following cycles with `x_valid` high, then IDLE.
  - A connected 11010 detector raises `y_out`.
- Two words 5'b11010 and 5'b10101 offered back-to-back:
  - 10 contiguous valid bits 1101010101.
  - `din_ready` high exactly at the IDLE edge and at the 5th-bit edge.
- `din_valid` held high through the word with `din` changed mid-word: the changed value is not sampled until the final-bit edge. Output matches the first word exactly.
- `rst` pulsed at the 3rd bit of 5'b11010:
  - `x_valid` = 0 and `x_out` = IDLE_BIT asynchronously.
  - After release, `din_ready` = 1 and no remaining bits are emitted.
- MSB_FIRST = 0, `din` = 5'b11010: output 0,1,0,1,1.
- `SER_PARITY_EN`, `din` = 5'b11010: output 1,1,0,1,0,1 (6 valid cycles). `din` = 5'b11000: parity bit 0.
